// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the ALU writeback stage:
//   DATA_W              default ALU result width
//   OP_*                ALU control codes 000-110 (111 is the no-flag op)
//   COND_*              branch condition codes
//   flags_t             architectural Z/N/C flags
//   cond_taken()        resolves a branch condition against a flags value
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 18;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_ANDI = 3'b110;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_Z      = 3'b001;
    localparam logic [2:0] COND_NZ     = 3'b010;
    localparam logic [2:0] COND_N      = 3'b011;
    localparam logic [2:0] COND_NN     = 3'b100;
    localparam logic [2:0] COND_C      = 3'b101;
    localparam logic [2:0] COND_NC     = 3'b110;
    localparam logic [2:0] COND_NEVER  = 3'b111;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
    } flags_t;

    function automatic logic cond_taken(input logic [2:0] cond, input flags_t f);
        logic taken;
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = f.z;
            COND_NZ:     taken = ~f.z;
            COND_N:      taken = f.n;
            COND_NN:     taken = ~f.n;
            COND_C:      taken = f.c;
            COND_NC:     taken = ~f.c;
            default:     taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// -----------------------------------------------------------------------------
// alu_wb_stage_if
// Upstream (ALU entry) and downstream (writeback entry) handshake bundle.
//   in_valid/in_ready        ALU entry handshake
//   in_result, in_zero/negative/carry, in_alu_op, in_rd, in_wen,
//   in_is_branch, in_cond    ALU entry payload
//   out_valid/out_ready      writeback handshake
//   out_data, out_rd, out_wen, out_taken   writeback payload
// Modports: slave = the stage itself, master = the surrounding pipeline.
// -----------------------------------------------------------------------------
interface alu_wb_stage_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_zero;
    logic              in_negative;
    logic              in_carry;
    logic [2:0]        in_alu_op;
    logic [REG_AW-1:0] in_rd;
    logic              in_wen;
    logic              in_is_branch;
    logic [2:0]        in_cond;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [REG_AW-1:0] out_rd;
    logic              out_wen;
    logic              out_taken;

    modport slave (
        input  in_valid, in_result, in_zero, in_negative, in_carry,
               in_alu_op, in_rd, in_wen, in_is_branch, in_cond, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_wen, out_taken
    );

    modport master (
        output in_valid, in_result, in_zero, in_negative, in_carry,
               in_alu_op, in_rd, in_wen, in_is_branch, in_cond, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_wen, out_taken
    );
endinterface

// File: rtl/wb_skid_fifo.sv
// -----------------------------------------------------------------------------
// wb_skid_fifo
// Entry buffer between the ALU and the writeback consumer.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_data    push side
//   out_valid/out_ready/out_data pop side (in order)
// Build option ALU_WB_SKID_EN:
//   defined   -> 2-entry buffer, in_ready registered as occupancy < 2
//   undefined -> 1-entry register, in_ready = !out_valid | out_ready
// -----------------------------------------------------------------------------
module wb_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

`ifdef ALU_WB_SKID_EN
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         ready_q;
    logic         push;
    logic         pop;

    assign push      = in_valid & ready_q;
    assign pop       = out_ready & (count != 2'd0);
    assign in_ready  = ready_q;
    assign out_valid = (count != 2'd0);
    assign out_data  = head;

    // NOTE: every variable assigned in always_comb gets a default first,
    // otherwise the untaken paths infer a latch.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (!push && pop) begin
            count_next = count - 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 2'd0;
            ready_q <= 1'b0;
            head    <= '0;
        end else begin
            count   <= count_next;
            // Registered ready: look ahead at next occupancy.
            ready_q <= (count_next != 2'd2);
            if (pop) begin
                if (count == 2'd2) begin
                    head <= tail;
                end else if (push) begin
                    head <= in_data;
                end
            end else if (push && count == 2'd0) begin
                head <= in_data;
            end
        end
    end

    // NOTE: the second slot is not reset; it is only read after a push has
    // written it, so a reset would add muxing for no observable benefit.
    always_ff @(posedge clk) begin
        if (push && !pop && count == 2'd1) begin
            tail <= in_data;
        end
    end
`else
    logic         valid;
    logic         ready_en;
    logic [W-1:0] head;
    logic         push;
    logic         pop;

    // ready_en holds in_ready low during reset and releases it one edge later.
    assign in_ready  = ready_en & (~valid | out_ready);
    assign push      = in_valid & in_ready;
    assign pop       = valid & out_ready;
    assign out_valid = valid;
    assign out_data  = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            ready_en <= 1'b0;
            head     <= '0;
        end else begin
            ready_en <= 1'b1;
            valid    <= push | (valid & ~pop);
            if (push) begin
                head <= in_data;
            end
        end
    end
`endif

endmodule

// File: rtl/alu_wb_stage.sv
// -----------------------------------------------------------------------------
// alu_wb_stage
// Writeback stage after the ALU: updates the Z/N/C flags register from ALU
// entries, resolves conditional branches against that register, and buffers
// the resulting writeback entries in order.
//   clk, rst             clock, synchronous active-high reset
//   bus (slave)          ALU entry in, writeback entry out (alu_wb_stage_if)
//   flag_z/flag_n/flag_c architectural flags register
// Build option ALU_WB_SKID_EN selects the 2-entry buffer in wb_skid_fifo.
// -----------------------------------------------------------------------------
module alu_wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_wb_stage_if.slave  bus,
    output logic           flag_z,
    output logic           flag_n,
    output logic           flag_c
);

    localparam int ENTRY_W = DATA_W + REG_AW + 2;

    flags_t               flags;
    logic                 fifo_ready;
    logic                 fifo_valid;
    logic                 push;
    logic                 branch_taken;
    logic [ENTRY_W-1:0]   entry_in;
    logic [ENTRY_W-1:0]   entry_out;

    assign push         = bus.in_valid & fifo_ready;
    assign bus.in_ready = fifo_ready;
    assign bus.out_valid = fifo_valid;

    // Branches see the flags as they stand before this edge.
    assign branch_taken = cond_taken(bus.in_cond, flags);

    // Branches never write the register file; non-branches are never taken.
    assign entry_in = {bus.in_result,
                       bus.in_rd,
                       bus.in_wen & ~bus.in_is_branch,
                       bus.in_is_branch & branch_taken};

    assign {bus.out_data, bus.out_rd, bus.out_wen, bus.out_taken} = entry_out;

    assign flag_z = flags.z;
    assign flag_n = flags.n;
    assign flag_c = flags.c;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else if (push && !bus.in_is_branch) begin
            case (bus.in_alu_op)
                OP_ADD, OP_ADDI, OP_SUB: begin
                    flags <= '{z: bus.in_zero, n: bus.in_negative, c: bus.in_carry};
                end
                OP_AND, OP_NAND, OP_NOR, OP_ANDI: begin
                    flags <= '{z: bus.in_zero, n: bus.in_negative, c: 1'b0};
                end
                default: begin
                    // 111 leaves the flags untouched.
                end
            endcase
        end
    end

    wb_skid_fifo #(
        .W(ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .in_ready (fifo_ready),
        .in_data  (entry_in),
        .out_valid(fifo_valid),
        .out_ready(bus.out_ready),
        .out_data (entry_out)
    );

endmodule

// File: tb/tb_alu_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_wb_stage
// Directed scenarios followed by randomized traffic. Expected writeback
// entries are queued at acceptance; a monitor pops and compares them whenever
// the stage presents an output transfer. Build option ALU_WB_SKID_EN must
// match the RTL build.
// -----------------------------------------------------------------------------
module tb_alu_wb_stage;
    import cpu_pkg::*;

    localparam int DW = 18;
    localparam int AW = 4;
`ifdef ALU_WB_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flag_z, flag_n, flag_c;

    always #5 clk = ~clk;

    alu_wb_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    alu_wb_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .flag_z(flag_z),
        .flag_n(flag_n),
        .flag_c(flag_c)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] rd;
        logic          wen;
        logic          taken;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mz = 1'b0, mn = 1'b0, mc = 1'b0;
    bit   rand_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Branch resolution straight from the condition table.
    function automatic bit ref_taken(input logic [2:0] cond, input bit z, input bit n, input bit c);
        bit t;
        case (cond)
            3'd0:    t = 1'b1;
            3'd1:    t = z;
            3'd2:    t = !z;
            3'd3:    t = n;
            3'd4:    t = !n;
            3'd5:    t = c;
            3'd6:    t = !c;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Monitor: one comparison per output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data %0h rd %0h, expected no entry",
                         bus.out_data, bus.out_rd);
            end else begin
                e = sb.pop_front();
                check("out_entry",
                      64'({bus.out_data, bus.out_rd, bus.out_wen, bus.out_taken}),
                      64'({e.data, e.rd, e.wen, e.taken}));
            end
        end
    end

    task automatic send(input logic [DW-1:0] res, input bit z, input bit n, input bit c,
                        input logic [2:0] op, input logic [AW-1:0] rd, input bit wen,
                        input bit br, input logic [2:0] cond);
        bit   acc;
        exp_t e;
        acc = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_result    = res;
        bus.in_zero      = z;
        bus.in_negative  = n;
        bus.in_carry     = c;
        bus.in_alu_op    = op;
        bus.in_rd        = rd;
        bus.in_wen       = wen;
        bus.in_is_branch = br;
        bus.in_cond      = cond;
        for (int k = 0; k < 64 && !acc; k++) begin
            if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_ready) begin
                acc     = 1'b1;
                e.data  = res;
                e.rd    = rd;
                e.wen   = br ? 1'b0 : wen;
                e.taken = br ? ref_taken(cond, mz, mn, mc) : 1'b0;
                sb.push_back(e);
                if (!br) begin
                    if (op inside {3'b000, 3'b101, 3'b100}) begin
                        mz = z; mn = n; mc = c;
                    end else if (op inside {3'b001, 3'b010, 3'b011, 3'b110}) begin
                        mz = z; mn = n; mc = 1'b0;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (acc) begin
            check("flags", 64'({flag_z, flag_n, flag_c}), 64'({mz, mn, mc}));
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 64 cycles");
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        rand_mode     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 100 && sb.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_result    = '0;
        bus.in_zero      = 1'b0;
        bus.in_negative  = 1'b0;
        bus.in_carry     = 1'b0;
        bus.in_alu_op    = 3'd0;
        bus.in_rd        = '0;
        bus.in_wen       = 1'b0;
        bus.in_is_branch = 1'b0;
        bus.in_cond      = 3'd0;
        bus.out_ready    = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_payload", 64'({bus.out_data, bus.out_rd, bus.out_wen, bus.out_taken}), 64'd0);
        check("rst_flags", 64'({flag_z, flag_n, flag_c}), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // SUB giving zero, then a branch on Z the next cycle.
        bus.out_ready = 1'b1;
        send(18'd0, 1'b1, 1'b0, 1'b0, 3'b100, 4'd1, 1'b1, 1'b0, 3'd0);
        check("sub_flag_z", 64'(flag_z), 64'd1);
        send(18'h155, 1'b0, 1'b0, 1'b0, 3'b000, 4'd2, 1'b1, 1'b1, 3'b001);
        check("branch_keeps_z", 64'(flag_z), 64'd1);

        // ADD sets carry, AND clears it even with in_carry=1.
        send(18'h3_0001, 1'b0, 1'b1, 1'b1, 3'b000, 4'd3, 1'b1, 1'b0, 3'd0);
        check("add_flag_c", 64'(flag_c), 64'd1);
        send(18'h0_00f0, 1'b0, 1'b0, 1'b1, 3'b001, 4'd4, 1'b1, 1'b0, 3'd0);
        check("and_flag_c", 64'(flag_c), 64'd0);

        // Op 111 does not touch flags.
        send(18'd3, 1'b0, 1'b0, 1'b0, 3'b100, 4'd5, 1'b1, 1'b0, 3'd0);
        check("sub3_flag_z", 64'(flag_z), 64'd0);
        send(18'd0, 1'b1, 1'b1, 1'b1, 3'b111, 4'd6, 1'b1, 1'b0, 3'd0);
        check("op7_flag_z", 64'(flag_z), 64'd0);
        drain();

        // Backpressure: fill to capacity, further entry must be held off.
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < CAP; i++) begin
            send(18'(20 + i), 1'b0, 1'b0, 1'b0, 3'b111, 4'(8 + i), 1'b1, 1'b0, 3'd0);
        end
        bus.in_valid  = 1'b1;
        bus.in_result = 18'd99;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_in_ready", 64'(bus.in_ready), 64'd0);
            check("full_out_valid", 64'(bus.out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();

        // Reset with held entries: all discarded, flags cleared.
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < CAP; i++) begin
            send(18'(40 + i), 1'b0, 1'b1, 1'b1, 3'b100, 4'(12 + i), 1'b1, 1'b0, 3'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_flags", 64'({flag_z, flag_n, flag_c}), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        sb.delete();
        mz = 1'b0; mn = 1'b0; mc = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_release_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("no_stale_entry", 64'(bus.out_valid), 64'd0);
        end

        // Randomized traffic with random backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(18'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 3'($urandom), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 3'($urandom));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
